md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage.
- Drives `busy`, which the stall controller uses to hold MFHI/MFLO and further MD instructions in D.
- Operation latencies are set by parameters. Supports flush from exception/interrupt at issue.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  valid MD instruction in E this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB (6/7 only with feature).
- a  input  WIDTH  rs operand (forwarded).
- b  input  WIDTH  rt operand (forwarded).
- flush  input  1  exception/interrupt taken on the instruction in E; cancels issue this cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: busy=0, done=0, hi=0, lo=0, counter=0, state IDLE. Reset wins over every other input, including mid-operation; the in-flight result is discarded.
- Issue condition: start=1 && busy=0 && flush=0. Start while busy=1 is ignored; the stall controller guarantees this does not occur. start with flush=1 has no effect of any kind.
- States:
  - IDLE: on issue of ops 0-3 (and 6/7 with the feature), latch a, b and op, load counter with N (MULT_CYCLES or DIV_CYCLES), go to BUSY.
  - BUSY: counter decrements each cycle. At counter==1, commit the result to HI/LO on that edge, go to IDLE.
- Timing: issue in cycle T → busy=1 in cycles T+1..T+N. New hi/lo and busy=0 are visible in T+N+1; done=1 in T+N+1 only. hi/lo hold their old values throughout BUSY.
- MTHI/MTLO: on issue, hi (resp. lo) ← a at the next edge. busy stays 0 and done stays 0.
- flush during BUSY does not cancel the operation; it was already committed to execute.
- Arithmetic:
  - MULT: signed, {hi,lo} ← a*b (2·WIDTH result).
  - MULTU: unsigned, {hi,lo} ← a*b.
  - DIV: signed. lo ← quotient truncated toward zero; hi ← remainder with the dividend's sign. Case a=MIN, b=−1: lo=MIN, hi=0.
  - DIVU: unsigned, lo ← a/b, hi ← a%b.
  - Divide by zero (DIV/DIVU, b=0): the operation still runs DIV_CYCLES, but hi/lo are left unchanged at commit. done still pulses.
- Operands are the values latched at issue. Changes on a/b during BUSY have no effect.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: op 6 MADD gives {hi,lo} ← {hi,lo} + signed(a*b); op 7 MSUB gives {hi,lo} ← {hi,lo} − signed(a*b). Both take MULT_CYCLES. The accumulate uses {hi,lo} as it stands at commit, which equals the value at issue, since nothing can write HI/LO while busy. The 2·WIDTH sum wraps modulo 2^(2·WIDTH).
- Undefined: op 6/7 are treated as no-ops. No busy, no HI/LO change, no done.

Test Plan:
1. Defaults. MULT a=0xFFFFFFFE (−2), b=3 issued at T → busy=1 T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
2. DIV a=−7, b=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=2 → lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
3. Preload hi=0x11, lo=0x22 via MTHI/MTLO; then DIVU a=5, b=0 → busy for 10 cycles, done pulses, hi=0x11 and lo=0x22 unchanged.
4. MULTU a=3, b=4 with flush=1 in the issue cycle → busy stays 0, hi/lo unchanged. Then flush=1 asserted during cycle T+2 of a running MULTU → result still commits (lo=12, hi=0).
5. reset=1 at cycle T+3 of a DIV → next cycle busy=0, hi=lo=0, done=0, and no commit occurs later. A second start while busy=1 is ignored and the latched operands are kept.
6. With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADD a=1, b=1 → hi=1, lo=0 after 5 cycles. MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF. Without the macro: op=6 → no busy, no change.

Source files
------------

// File: rtl/md_unit_if.sv
// Issue/result bundle between the E-stage issue logic and the multiply/divide unit.
// The master side issues MD instructions; the slave side owns HI/LO and reports progress.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the pipelined MIPS core.
// Optional MADD/MSUB accumulate ops are enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave io
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [CW-1:0]      count_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;

  logic               issue;
  logic               long_op;
  logic [CW-1:0]      load_count;
  logic               commit_we;
  logic [2*WIDTH-1:0] commit_val;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mr;
  logic [WIDTH-1:0]   sq;
  logic [WIDTH-1:0]   sr;

  assign issue   = io.start && !busy_reg && !io.flush;
  assign io.busy = busy_reg;
  assign io.done = done_reg;
  assign io.hi   = hi_reg;
  assign io.lo   = lo_reg;

  always_comb begin
    long_op    = 1'b0;
    load_count = CW'(MULT_CYCLES);
    case (io.op)
      OP_MULT, OP_MULTU: long_op = 1'b1;
      OP_DIV, OP_DIVU: begin
        long_op    = 1'b1;
        load_count = CW'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MSUB: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  // Arithmetic works on the latched operands only; it settles over the busy window.
  always_comb begin
    prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
    prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    a_neg  = a_reg[WIDTH-1];
    b_neg  = b_reg[WIDTH-1];
    a_mag  = a_neg ? -a_reg : a_reg;
    b_mag  = b_neg ? -b_reg : b_reg;
    uq     = (b_reg == '0) ? '0 : a_reg / b_reg;
    ur     = (b_reg == '0) ? '0 : a_reg % b_reg;
    mq     = (b_mag == '0) ? '0 : a_mag / b_mag;
    mr     = (b_mag == '0) ? '0 : a_mag % b_mag;
    // Sign-magnitude fixup also yields MIN / -1 = MIN with remainder 0.
    sq     = (a_neg ^ b_neg) ? -mq : mq;
    sr     = a_neg ? -mr : mr;
  end

  always_comb begin
    commit_we  = 1'b1;
    commit_val = {hi_reg, lo_reg};
    case (op_reg)
      OP_MULT:  commit_val = prod_s;
      OP_MULTU: commit_val = prod_u;
      OP_DIV: begin
        commit_we  = (b_reg != '0);
        commit_val = {sr, sq};
      end
      OP_DIVU: begin
        commit_we  = (b_reg != '0);
        commit_val = {ur, uq};
      end
`ifdef MD_MADD_EN
      OP_MADD: commit_val = {hi_reg, lo_reg} + prod_s;
      OP_MSUB: commit_val = {hi_reg, lo_reg} - prod_s;
`endif
      default: commit_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      count_reg <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue) begin
            if (long_op) begin
              op_reg    <= io.op;
              a_reg     <= io.a;
              b_reg     <= io.b;
              count_reg <= load_count;
              busy_reg  <= 1'b1;
              state_reg <= BUSY;
            end else if (io.op == OP_MTHI) begin
              hi_reg <= io.a;
            end else if (io.op == OP_MTLO) begin
              lo_reg <= io.a;
            end
          end
        end
        BUSY: begin
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            if (commit_we) begin
              {hi_reg, lo_reg} <= commit_val;
            end
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and completion cycle,
// a negedge monitor checks busy every cycle and pops/compares on each done pulse.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   cyc;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    int          cyc;
    logic [63:0] hl;
    logic [2:0]  op;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  int          bstart;
  int          bend;
  int          n_checks;
  int          n_fail;
  bit          mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions.
  task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [63:0] res);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = {hi_m, lo_m};
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
`ifdef MD_MADD_EN
      3'd6: res = {hi_m, lo_m} + 64'(sa * sb);
      3'd7: res = {hi_m, lo_m} - 64'(sa * sb);
`endif
      default: res = {hi_m, lo_m};
    endcase
  endtask

  function automatic bit is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
    return op != 3'd4 && op != 3'd5;
`else
    return op <= 3'd3;
`endif
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic [63:0] res;
    int          n;
    exp_t        e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.flush = fl;
    if (!fl && !(cyc >= bstart && cyc <= bend)) begin
      if (is_long(op)) begin
        n = (op == 3'd2 || op == 3'd3) ? DC : MC;
        model_result(op, a, b, res);
        e.cyc  = cyc + 1 + n;
        e.hl   = res;
        e.op   = op;
        exp_q.push_back(e);
        bstart = cyc + 1;
        bend   = cyc + n;
        hi_m   = res[63:32];
        lo_m   = res[31:0];
      end else if (op == 3'd4) begin
        hi_m = a;
      end else if (op == 3'd5) begin
        lo_m = a;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_idle();
    while (cyc <= bend + 1) @(posedge clk);
    #1;
  endtask

  task automatic check_hl(string name);
    @(negedge clk);
    chk({name, "_hi"}, {32'd0, bus.hi}, {32'd0, hi_m});
    chk({name, "_lo"}, {32'd0, bus.lo}, {32'd0, lo_m});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", {63'd0, bus.busy}, {63'd0, (cyc >= bstart && cyc <= bend)});
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hilo", {bus.hi, bus.lo}, e.hl);
          $display("txn op=%0d cycle=%0d hi=%h lo=%h", e.op, cyc, bus.hi, bus.lo);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("done_timeout", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    cyc = 0; n_checks = 0; n_fail = 0; mon_en = 1'b0;
    hi_m = '0; lo_m = '0; bstart = 1; bend = 0;
    reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    check_hl("reset");

    // Directed cases
    drive(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0); wait_idle(); check_hl("mult");
    drive(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); wait_idle(); check_hl("div_neg");
    drive(3'd3, 32'd7, 32'd2, 1'b0); wait_idle(); check_hl("divu");
    drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle(); check_hl("div_min");
    drive(3'd4, 32'h11, 32'd0, 1'b0); drive(3'd5, 32'h22, 32'd0, 1'b0); check_hl("mt");
    drive(3'd3, 32'd5, 32'd0, 1'b0); wait_idle(); check_hl("divz");
    drive(3'd1, 32'd3, 32'd4, 1'b1); check_hl("flush_issue");
    drive(3'd1, 32'd3, 32'd4, 1'b0);
    bus.flush = 1'b1; @(posedge clk); #1 bus.flush = 1'b0;
    wait_idle(); check_hl("flush_busy");

    // Start while busy is ignored; original operands kept
    drive(3'd2, 32'd100, 32'd7, 1'b0);
    drive(3'd0, 32'd9, 32'd9, 1'b0);
    wait_idle(); check_hl("start_busy");

    // Reset mid-operation discards the in-flight result
    drive(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    bend  = (bend < cyc) ? bend : cyc;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    exp_q.delete();
    check_hl("reset_mid");
    repeat (DC + 2) @(posedge clk);
    check_hl("reset_after");

`ifdef MD_MADD_EN
    drive(3'd4, 32'd0, 32'd0, 1'b0); drive(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    drive(3'd6, 32'd1, 32'd1, 1'b0); wait_idle(); check_hl("madd");
    drive(3'd7, 32'd1, 32'd1, 1'b0); wait_idle(); check_hl("msub");
`else
    drive(3'd6, 32'd1, 32'd1, 1'b0); check_hl("op6_nop");
    drive(3'd7, 32'd1, 32'd1, 1'b0); check_hl("op7_nop");
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(op, a, b, ($urandom_range(0, 7) == 0));
      wait_idle();
      check_hl("rand");
    end

    repeat (DC + 4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
